// File: rtl/keycode_rx.sv
// rtl/keycode_rx.sv - key press validation and first-word-fall-through press queue
//
// Purpose:
//   Accepts one-cycle key press strobes with a 5-bit key code, rejects
//   illegal codes, and queues legal presses in a small FWFT FIFO. The head
//   entry is presented to game logic on a valid/ready interface as both a
//   binary code and a one-hot key vector.
//
// Ports:
//   clk        in   system clock, rising edge
//   nrst       in   asynchronous active-low reset
//   key_code   in   key code, sampled only with key_strobe
//   key_strobe in   one-cycle press pulse
//   rd_ready   in   consumer takes the head entry this cycle
//   clr_err    in   synchronous clear of the sticky error flags
//   rd_valid   out  queue non-empty, head entry presented
//   rd_code    out  head entry code, 0 when empty
//   rd_onehot  out  one-hot of rd_code, all zeros when empty
//   count      out  number of stored entries
//   overflow   out  sticky: a legal press was dropped because the queue was full
//   bad_code   out  sticky: a strobe carried a code >= NKEYS

module keycode_rx #(
  parameter int DEPTH = 4,
  parameter int NKEYS = 20
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [4:0]                 key_code,
  input  logic                       key_strobe,
  input  logic                       rd_ready,
  input  logic                       clr_err,
  output logic                       rd_valid,
  output logic [4:0]                 rd_code,
  output logic [NKEYS-1:0]           rd_onehot,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic                       bad_code
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // One extra bit so NKEYS = 32 still compares correctly against a 5-bit code.
  localparam logic [5:0]    NKEYS_W = 6'(NKEYS);
  localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

  logic [4:0]    mem_q [DEPTH];
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          overflow_q, overflow_d;
  logic          bad_code_q, bad_code_d;

  logic code_ok;
  logic full;
  logic pop;
  logic push;
  logic ovf_event;
  logic bad_event;

  assign code_ok   = ({1'b0, key_code} < NKEYS_W);
  assign full      = (count_q == DEPTH_W);
  assign rd_valid  = (count_q != '0);
  // A pop is only possible when something is stored; rd_ready on empty is ignored.
  assign pop       = rd_valid & rd_ready;
  // When full, a same-cycle pop frees the slot the push will occupy.
  assign push      = key_strobe & code_ok & (~full | pop);
  assign ovf_event = key_strobe & code_ok & full & ~pop;
  assign bad_event = key_strobe & ~code_ok;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Error events win over a coincident clear so no event is lost.
  always_comb begin
    overflow_d = ovf_event | (overflow_q & ~clr_err);
    bad_code_d = bad_event | (bad_code_q & ~clr_err);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      bad_code_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      bad_code_q <= bad_code_d;
    end
  end

  // Storage contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= key_code;
    end
  end

  assign rd_code = rd_valid ? mem_q[rd_ptr_q[AW-1:0]] : 5'd0;

  always_comb begin
    rd_onehot = '0;
    for (int i = 0; i < NKEYS; i++) begin
      rd_onehot[i] = rd_valid & (rd_code == 5'(i));
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign bad_code = bad_code_q;

endmodule

// File: tb/tb_keycode_rx.sv
// tb/tb_keycode_rx.sv - self-checking bench for keycode_rx

module tb_keycode_rx;

  logic        clk;
  logic        nrst;
  logic [4:0]  key_code;
  logic        key_strobe;
  logic        rd_ready;
  logic        clr_err;
  logic        rd_valid;
  logic [4:0]  rd_code;
  logic [19:0] rd_onehot;
  logic [2:0]  count;
  logic        overflow;
  logic        bad_code;

  int checks;
  int errors;

  keycode_rx #(.DEPTH(4), .NKEYS(20)) dut (
    .clk        (clk),
    .nrst       (nrst),
    .key_code   (key_code),
    .key_strobe (key_strobe),
    .rd_ready   (rd_ready),
    .clr_err    (clr_err),
    .rd_valid   (rd_valid),
    .rd_code    (rd_code),
    .rd_onehot  (rd_onehot),
    .count      (count),
    .overflow   (overflow),
    .bad_code   (bad_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       stb;
    logic [4:0] code;
    logic       rdy;
    logic       clr;
    logic       e_valid;
    logic [4:0] e_code;
    logic [2:0] e_count;
    logic       e_ovf;
    logic       e_bad;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic stb, input logic [4:0] code, input logic rdy, input logic clr);
    key_strobe = stb;
    key_code   = code;
    rd_ready   = rdy;
    clr_err    = clr;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " rd_valid"},  32'(rd_valid),  32'h0);
    check({tag, " rd_code"},   32'(rd_code),   32'h0);
    check({tag, " rd_onehot"}, 32'(rd_onehot), 32'h0);
    check({tag, " count"},     32'(count),     32'h0);
    check({tag, " overflow"},  32'(overflow),  32'h0);
    check({tag, " bad_code"},  32'(bad_code),  32'h0);
  endtask

  task automatic add(input logic stb, input logic [4:0] code, input logic rdy, input logic clr,
                     input logic ev, input logic [4:0] ec, input logic [2:0] en,
                     input logic eo, input logic eb);
    vec_t v;
    v.stb = stb; v.code = code; v.rdy = rdy; v.clr = clr;
    v.e_valid = ev; v.e_code = ec; v.e_count = en; v.e_ovf = eo; v.e_bad = eb;
    vecs.push_back(v);
  endtask

  // Random-traffic reference model
  logic [4:0] q[$];
  logic       m_ovf;

  initial begin
    checks = 0;
    errors = 0;
    nrst = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 1'b0);
    tick();
    tick();
    check_all_zero("reset");

    // Release reset; the first edge afterwards must accept the push of code 7.
    nrst = 1'b1;
    drive(1'b1, 5'd7, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 1'b0, 1'b0);
    check("first rd_valid",  32'(rd_valid),  32'h1);
    check("first rd_code",   32'(rd_code),   32'h7);
    check("first rd_onehot", 32'(rd_onehot), 32'h00080);
    check("first count",     32'(count),     32'h1);
    tick();
    check("hold rd_code", 32'(rd_code), 32'h7);

    // Asynchronous reset pulse in the middle of a clock period discards the entry.
    #2 nrst = 1'b0;
    #1 check_all_zero("async rst");
    #1 nrst = 1'b1;
    tick();
    check_all_zero("post rst");

    // Table: inputs for one cycle, expected outputs after that cycle's edge.
    //   stb code rdy clr | valid code count ovf bad
    add(1, 5'd3,  0, 0,   1, 5'd3,  3'd1, 0, 0);
    add(1, 5'd19, 0, 0,   1, 5'd3,  3'd2, 0, 0);
    add(1, 5'd0,  0, 0,   1, 5'd3,  3'd3, 0, 0);
    add(1, 5'd12, 0, 0,   1, 5'd3,  3'd4, 0, 0);
    add(1, 5'd5,  0, 0,   1, 5'd3,  3'd4, 1, 0);  // full, no pop: dropped
    add(0, 5'd0,  1, 0,   1, 5'd19, 3'd3, 1, 0);
    add(0, 5'd0,  1, 0,   1, 5'd0,  3'd2, 1, 0);
    add(0, 5'd0,  1, 0,   1, 5'd12, 3'd1, 1, 0);
    add(0, 5'd0,  1, 0,   0, 5'd0,  3'd0, 1, 0);
    add(0, 5'd0,  0, 1,   0, 5'd0,  3'd0, 0, 0);  // clear overflow
    add(1, 5'd1,  0, 0,   1, 5'd1,  3'd1, 0, 0);
    add(1, 5'd2,  0, 0,   1, 5'd1,  3'd2, 0, 0);
    add(1, 5'd3,  0, 0,   1, 5'd1,  3'd3, 0, 0);
    add(1, 5'd4,  0, 0,   1, 5'd1,  3'd4, 0, 0);
    add(1, 5'd9,  1, 0,   1, 5'd2,  3'd4, 0, 0);  // full with pop: accepted
    add(0, 5'd0,  1, 0,   1, 5'd3,  3'd3, 0, 0);
    add(0, 5'd0,  1, 0,   1, 5'd4,  3'd2, 0, 0);
    add(0, 5'd0,  1, 0,   1, 5'd9,  3'd1, 0, 0);
    add(0, 5'd0,  1, 0,   0, 5'd0,  3'd0, 0, 0);
    add(1, 5'd20, 0, 0,   0, 5'd0,  3'd0, 0, 1);  // illegal codes
    add(1, 5'd31, 0, 0,   0, 5'd0,  3'd0, 0, 1);
    add(0, 5'd0,  0, 1,   0, 5'd0,  3'd0, 0, 0);
    add(1, 5'd20, 0, 1,   0, 5'd0,  3'd0, 0, 1);  // set wins over clear
    add(0, 5'd0,  0, 1,   0, 5'd0,  3'd0, 0, 0);
    add(1, 5'd1,  1, 0,   1, 5'd1,  3'd1, 0, 0);  // empty + ready: no pop
    add(0, 5'd0,  1, 0,   0, 5'd0,  3'd0, 0, 0);
    add(0, 5'd0,  1, 0,   0, 5'd0,  3'd0, 0, 0);  // no underflow
    add(1, 5'd0,  1, 0,   1, 5'd0,  3'd1, 0, 0);  // push into empty with ready held
    add(1, 5'd18, 1, 0,   1, 5'd18, 3'd1, 0, 0);  // push+pop, one deep
    add(0, 5'd0,  1, 0,   0, 5'd0,  3'd0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      logic [19:0] exp_oh;
      drive(vecs[i].stb, vecs[i].code, vecs[i].rdy, vecs[i].clr);
      tick();
      exp_oh = vecs[i].e_valid ? (20'h1 << vecs[i].e_code) : 20'h0;
      check($sformatf("vec%0d rd_valid", i),  32'(rd_valid),  32'(vecs[i].e_valid));
      check($sformatf("vec%0d rd_code", i),   32'(rd_code),   32'(vecs[i].e_code));
      check($sformatf("vec%0d rd_onehot", i), 32'(rd_onehot), 32'(exp_oh));
      check($sformatf("vec%0d count", i),     32'(count),     32'(vecs[i].e_count));
      check($sformatf("vec%0d overflow", i),  32'(overflow),  32'(vecs[i].e_ovf));
      check($sformatf("vec%0d bad_code", i),  32'(bad_code),  32'(vecs[i].e_bad));
    end
    drive(1'b0, 5'd0, 1'b0, 1'b0);

    // Random traffic against a queue model; state is empty with flags clear here.
    m_ovf = 1'b0;
    for (int c = 0; c < 10000; c++) begin
      logic       stb, rdy, clr, ok, mpop, mpush, ev;
      logic [4:0] code;
      stb  = 1'($urandom_range(0, 1));
      code = 5'($urandom_range(0, 22));
      rdy  = 1'($urandom_range(0, 2) == 0);
      clr  = 1'($urandom_range(0, 63) == 0);
      ok    = (code < 5'd20);
      mpop  = (q.size() > 0) && rdy;
      mpush = stb && ok && ((q.size() < 4) || mpop);
      ev    = stb && ok && (q.size() == 4) && !mpop;
      drive(stb, code, rdy, clr);
      tick();
      if (mpop)  void'(q.pop_front());
      if (mpush) q.push_back(code);
      m_ovf = ev | (m_ovf & ~clr);
      check("rnd rd_valid", 32'(rd_valid), 32'(q.size() > 0));
      check("rnd rd_code",  32'(rd_code),  (q.size() > 0) ? 32'(q[0]) : 32'h0);
      check("rnd count",    32'(count),    32'(q.size()));
      check("rnd overflow", 32'(overflow), 32'(m_ovf));
    end
    drive(1'b0, 5'd0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
